mul_shift_add_64: RTL

- Multi-cycle 32x32->64 integer multiplier for the EX stage.
- Iterates shift-and-add through the team's 64-bit carry-select adder (carry_select_adder_16bit, 64-bit datapath), one partial product per cycle.
- Fed by ID/EX operands via a start/busy/done handshake; the product goes to the EX/MEM result mux.
- The hazard unit stalls the pipe while busy=1.

---
 rtl/mul_shift_add_64.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mul_shift_add_64.sv
// Multi-cycle 32x32->64 shift-and-add multiplier for the EX stage, plus the
// carry-select adder it iterates through (one partial product per cycle).

module carry_select_adder_16bit #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    localparam int BLK = 16;
    localparam int NB  = W / BLK;

    logic [NB:0] carry;
    assign carry[0] = cin;

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_blk
            logic [BLK:0] sum0;
            logic [BLK:0] sum1;
            // Both carry-in hypotheses are precomputed; the real carry only selects.
            assign sum0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
            assign sum1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
            assign sum[g*BLK +: BLK] = carry[g] ? sum1[BLK-1:0] : sum0[BLK-1:0];
            assign carry[g+1]        = carry[g] ? sum1[BLK] : sum0[BLK];
        end
    endgenerate
endmodule

module mul_shift_add_64 #(
    parameter bit SIGNED_EN = 1'b1,
    parameter int OP_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                flush,
    input  logic                signed_op,
    input  logic [OP_W-1:0]     op_a,
    input  logic [OP_W-1:0]     op_b,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W-1:0]   product
);
    localparam int PW    = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OP_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [OP_W-1:0]  mplier;
    logic             neg;

    logic             sgn;
    logic [OP_W-1:0]  mag_a;
    logic [OP_W-1:0]  mag_b;

    logic [PW-1:0]    add_a;
    logic [PW-1:0]    add_b;
    logic             add_cin;
    logic [PW-1:0]    add_sum;

    // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
    assign sgn   = signed_op & SIGNED_EN;
    assign mag_a = (sgn && op_a[OP_W-1]) ? (~op_a + {{(OP_W-1){1'b0}}, 1'b1}) : op_a;
    assign mag_b = (sgn && op_b[OP_W-1]) ? (~op_b + {{(OP_W-1){1'b0}}, 1'b1}) : op_b;

    // The single adder accumulates in RUN and two's-complements the result in FIX.
    always_comb begin
        add_a   = acc;
        add_b   = mcand;
        add_cin = 1'b0;
        if (state == FIX) begin
            add_a   = ~acc;
            add_b   = '0;
            add_cin = 1'b1;
        end
    end

    carry_select_adder_16bit #(.W(PW)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else if (flush && state != IDLE) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        state  <= RUN;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{OP_W{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= sgn & (op_a[OP_W-1] ^ op_b[OP_W-1]);
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= add_sum;
                    mcand  <= {mcand[PW-2:0], 1'b0};
                    mplier <= {1'b0, mplier[OP_W-1:1]};
                    cnt    <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    product <= neg ? add_sum : acc;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
